// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register bank's single write port, plus a
// pending-write scoreboard that decode uses to stall stale operand reads.
module rf_wb_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_addr,
  input  logic [AW-1:0]     q_addr_a,
  input  logic [AW-1:0]     q_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [2**AW-1:0]  pend_mask,
  output logic              reg_wr,
  output logic [AW-1:0]     dir_wra,
  output logic [DW-1:0]     di
);

  localparam int NR = 2**AW;

  logic              last_grant_b_r;
  logic              reg_wr_r;
  logic [AW-1:0]     dir_wra_r;
  logic [DW-1:0]     di_r;
  logic [NR-1:0]     pend_r;

  logic              grant_a_s;
  logic              grant_b_s;
  logic              xfer_s;
  logic [AW-1:0]     win_addr_s;
  logic [DW-1:0]     win_data_s;
  logic [NR-1:0]     pend_nxt_s;

  // Grant selection from valids and the last winner only.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (a_valid && b_valid) begin
      if (RR_EN != 0) begin
        grant_a_s = last_grant_b_r;
        grant_b_s = ~last_grant_b_r;
      end else begin
        grant_a_s = 1'b1;
        grant_b_s = 1'b0;
      end
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
  end

  assign a_ready    = grant_a_s;
  assign b_ready    = grant_b_s;
  assign xfer_s     = grant_a_s | grant_b_s;
  assign win_addr_s = grant_a_s ? a_addr : b_addr;
  assign win_data_s = grant_a_s ? a_data : b_data;

  // Scoreboard next state: a new issue outranks the commit clearing the same bit.
  always_comb begin
    pend_nxt_s = pend_r;
    if (reg_wr_r) begin
      pend_nxt_s[dir_wra_r] = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (issue_valid && (issue_addr != {AW{1'b0}})) begin
      pend_nxt_s[issue_addr] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Write-port pipeline register, grant history and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_b_r <= 1'b1;
      reg_wr_r       <= 1'b0;
      dir_wra_r      <= {AW{1'b0}};
      di_r           <= {DW{1'b0}};
      pend_r         <= {NR{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      if (xfer_s) begin
        last_grant_b_r <= grant_b_s;
        reg_wr_r       <= (win_addr_s != {AW{1'b0}});
        dir_wra_r      <= win_addr_s;
        di_r           <= win_data_s;
      end else begin
        reg_wr_r       <= 1'b0;
      end
    end
  end

  // Register 0 is hard-wired, so it never reads as hazarded.
  assign hazard_a  = (q_addr_a != {AW{1'b0}}) && pend_r[q_addr_a];
  assign hazard_b  = (q_addr_b != {AW{1'b0}}) && pend_r[q_addr_b];
  assign pend_mask = pend_r;
  assign reg_wr    = reg_wr_r;
  assign dir_wra   = dir_wra_r;
  assign di        = di_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a round-robin instance is scoreboarded
// against a small reference model; a fixed-priority instance shares its inputs.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  a_addr = 5'd0, b_addr = 5'd0, issue_addr = 5'd0;
  logic [4:0]  q_addr_a = 5'd0, q_addr_b = 5'd0;
  logic [31:0] a_data = 32'd0, b_data = 32'd0;

  logic        a_ready, b_ready, hazard_a, hazard_b, reg_wr;
  logic [31:0] pend_mask;
  logic [4:0]  dir_wra;
  logic [31:0] di;

  logic        fp_a_ready, fp_b_ready, fp_hazard_a, fp_hazard_b, fp_reg_wr;
  logic [31:0] fp_pend_mask;
  logic [4:0]  fp_dir_wra;
  logic [31:0] fp_di;

  rf_wb_arbiter #(.AW(5), .DW(32), .RR_EN(1)) u_rr (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .pend_mask(pend_mask),
    .reg_wr(reg_wr), .dir_wra(dir_wra), .di(di)
  );

  rf_wb_arbiter #(.AW(5), .DW(32), .RR_EN(0)) u_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(fp_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(fp_b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
    .hazard_a(fp_hazard_a), .hazard_b(fp_hazard_b), .pend_mask(fp_pend_mask),
    .reg_wr(fp_reg_wr), .dir_wra(fp_dir_wra), .di(fp_di)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        xfer;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state
  logic        m_last_b;
  logic [31:0] m_pend;
  logic        m_wr;
  logic [4:0]  m_dir;
  logic [31:0] m_di;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_last_b = 1'b1;
    m_pend   = 32'd0;
    m_wr     = 1'b0;
    m_dir    = 5'd0;
    m_di     = 32'd0;
    exp_q.delete();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_dir_wra", {27'd0, dir_wra}, 32'd0);
    chk("rst_di", di, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, check, then advance the model past the next posedge.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ia,
                      input logic [4:0] qa, input logic [4:0] qb, input string tag);
    wb_exp_t e;
    logic    ear, ebr;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    issue_valid = iv; issue_addr = ia;
    q_addr_a = qa; q_addr_b = qb;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_wr = e.wr;
      if (e.xfer) begin
        m_dir = e.addr;
        m_di  = e.data;
      end
    end else begin
      m_wr = 1'b0;
    end
    ear = av && (!bv || m_last_b);
    ebr = bv && (!av || !m_last_b);
    chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ear});
    chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
    chk({tag, "_fp_a_ready"}, {31'd0, fp_a_ready}, {31'd0, av});
    chk({tag, "_fp_b_ready"}, {31'd0, fp_b_ready}, {31'd0, bv && !av});
    chk({tag, "_reg_wr"}, {31'd0, reg_wr}, {31'd0, m_wr});
    chk({tag, "_dir_wra"}, {27'd0, dir_wra}, {27'd0, m_dir});
    chk({tag, "_di"}, di, m_di);
    chk({tag, "_pend"}, pend_mask, m_pend);
    chk({tag, "_hazard_a"}, {31'd0, hazard_a}, {31'd0, (qa != 5'd0) && m_pend[qa]});
    chk({tag, "_hazard_b"}, {31'd0, hazard_b}, {31'd0, (qb != 5'd0) && m_pend[qb]});
    e.xfer = ear | ebr;
    e.addr = ear ? aa : ba;
    e.data = ear ? ad : bd;
    e.wr   = e.xfer && (e.addr != 5'd0);
    exp_q.push_back(e);
    if (e.xfer) m_last_b = ebr;
    if (m_wr) m_pend[m_dir] = 1'b0;
    if (iv && ia != 5'd0) m_pend[ia] = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Single write: issue r7, A writes 0x1234 two cycles later.
    step(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, "sw_c0");
    step(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, "sw_c1");
    step(1'b1, 5'd7, 32'h1234,   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, "sw_c2");
    step(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, "sw_c3");
    step(1'b0, 5'd0, 32'd0,      1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, "sw_c4");
    chk("sw_final_reg_wr", {31'd0, reg_wr}, 32'd0);

    // Contention from reset: RR alternates A,B,A,B; fixed priority keeps A.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'hA0A0_0003, 1'b1, 5'd4, 32'hB0B0_0004, 1'b0, 5'd0, 5'd3, 5'd4, "ct");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, "ct_tail");
    chk("ct_last_di_b", di, 32'hB0B0_0004);

    // Register 0: accepted, never written, never pending.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0, "r0_xfer");
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd0, 5'd0, "r0_after");
    chk("r0_di_updated", di, 32'hFFFF);

    // Set/clear collision on r5: the new issue keeps the bit set.
    step(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, "col_iss");
    step(1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, "col_wr");
    step(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, "col_both");
    step(1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, "col_after");
    chk("col_pend5", {31'd0, pend_mask[5]}, 32'd1);

    // Reset mid-operation with reg_wr=1 and pend_mask=0x90.
    do_reset();
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 5'd0, "rm_i4");
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0, "rm_i7");
    step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, "rm_wr");
    step(1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd4, "rm_live");
    chk("rm_pre_pend", pend_mask, 32'h0000_0090);
    chk("rm_pre_reg_wr", {31'd0, reg_wr}, 32'd1);
    do_reset();
    step(1'b1, 5'd1, 32'hAAAA, 1'b1, 5'd2, 32'hBBBB, 1'b0, 5'd0, 5'd7, 5'd4, "rm_first");
    chk("rm_first_a_wins", {31'd0, a_ready}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, "rm_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
